// File: rtl/iq_wakeup_if.sv
// Issue-queue wakeup bundle: allocation, deallocation, grant broadcast
// inputs and the registered ready/valid state that comes back out.
interface iq_wakeup_if #(
  parameter int PRF_WIDTH = 6,
  parameter int DEPTH     = 16,
  parameter int NPORT     = 4
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                       flush;
  logic                       alloc_en;
  logic [IDX_W-1:0]           alloc_idx;
  logic [PRF_WIDTH-1:0]       alloc_prs1;
  logic [PRF_WIDTH-1:0]       alloc_prs2;
  logic                       alloc_rdy1;
  logic                       alloc_rdy2;
  logic                       dealloc_en;
  logic [IDX_W-1:0]           dealloc_idx;
  logic [NPORT-1:0]           grant_vld;
  logic [NPORT*PRF_WIDTH-1:0] grant_tag;
  logic [DEPTH-1:0]           entry_vld;
  logic [DEPTH-1:0]           prs1_rdy;
  logic [DEPTH-1:0]           prs2_rdy;
  logic [NPORT-1:0]           bcast_vld;
  logic [NPORT*PRF_WIDTH-1:0] bcast_tag;

  modport master (
    output flush, alloc_en, alloc_idx, alloc_prs1, alloc_prs2, alloc_rdy1, alloc_rdy2,
    output dealloc_en, dealloc_idx, grant_vld, grant_tag,
    input  entry_vld, prs1_rdy, prs2_rdy, bcast_vld, bcast_tag
  );

  modport slave (
    input  flush, alloc_en, alloc_idx, alloc_prs1, alloc_prs2, alloc_rdy1, alloc_rdy2,
    input  dealloc_en, dealloc_idx, grant_vld, grant_tag,
    output entry_vld, prs1_rdy, prs2_rdy, bcast_vld, bcast_tag
  );
endinterface

// File: rtl/iq_wakeup.sv
// Latency-aware wakeup for the integer issue queue. Each grant port feeds a
// delay line matching its functional-unit latency; the line outputs are the
// broadcasts that set sticky per-entry source-ready bits. Allocation snoops
// the same broadcasts so a tag waking up in the alloc cycle is not lost.
module iq_wakeup #(
  parameter int                 PRF_WIDTH = 6,
  parameter int                 DEPTH     = 16,
  parameter int                 IDX_W     = $clog2(DEPTH),
  parameter int                 NPORT     = 4,
  parameter logic [3*NPORT-1:0] PORT_LAT  = {3'd3, 3'd1, 3'd1, 3'd1}
) (
  input logic       clk,
  input logic       rst,
  iq_wakeup_if.slave bus
);

  logic [NPORT-1:0]           bcast_vld;
  logic [NPORT*PRF_WIDTH-1:0] bcast_tag;

  logic [IDX_W-1:0]     alloc_idx;
  logic [IDX_W-1:0]     dealloc_idx;
  logic [DEPTH-1:0]     entry_vld;
  logic [DEPTH-1:0]     rdy1;
  logic [DEPTH-1:0]     rdy2;
  logic [PRF_WIDTH-1:0] prs1 [DEPTH];
  logic [PRF_WIDTH-1:0] prs2 [DEPTH];
  logic [DEPTH-1:0]     hit1;
  logic [DEPTH-1:0]     hit2;
  logic                 byp1;
  logic                 byp2;

  assign alloc_idx   = bus.alloc_idx;
  assign dealloc_idx = bus.dealloc_idx;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    localparam int L = int'(PORT_LAT[3*p +: 3]);

    if (L <= 1) begin : g_comb
      // Single-cycle units broadcast in their grant cycle.
      assign bcast_vld[p]                         = bus.grant_vld[p];
      assign bcast_tag[p*PRF_WIDTH +: PRF_WIDTH] = bus.grant_tag[p*PRF_WIDTH +: PRF_WIDTH];
    end else begin : g_pipe
      localparam int NSTG = L - 1;
      logic [NSTG-1:0]      vld_q;
      logic [PRF_WIDTH-1:0] tag_q [NSTG];

      // Free-running delay line; a flush discards everything in flight,
      // including the grant presented in the flush cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int k = 0; k < NSTG; k++) tag_q[k] <= '0;
        end else if (bus.flush) begin
          vld_q <= '0;
          for (int k = 0; k < NSTG; k++) tag_q[k] <= '0;
        end else begin
          vld_q[0] <= bus.grant_vld[p];
          tag_q[0] <= bus.grant_tag[p*PRF_WIDTH +: PRF_WIDTH];
          for (int k = 1; k < NSTG; k++) begin
            vld_q[k] <= vld_q[k-1];
            tag_q[k] <= tag_q[k-1];
          end
        end
      end

      assign bcast_vld[p]                         = vld_q[NSTG-1];
      assign bcast_tag[p*PRF_WIDTH +: PRF_WIDTH] = tag_q[NSTG-1];
    end
  end

  // Compare every broadcast against stored sources and the incoming alloc.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    byp1 = 1'b0;
    byp2 = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (bcast_vld[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (bcast_tag[p*PRF_WIDTH +: PRF_WIDTH] == prs1[i]) hit1[i] = 1'b1;
          if (bcast_tag[p*PRF_WIDTH +: PRF_WIDTH] == prs2[i]) hit2[i] = 1'b1;
        end
        if (bcast_tag[p*PRF_WIDTH +: PRF_WIDTH] == bus.alloc_prs1) byp1 = 1'b1;
        if (bcast_tag[p*PRF_WIDTH +: PRF_WIDTH] == bus.alloc_prs2) byp2 = 1'b1;
      end
    end
  end

  // Entry state: wakeup first, then dealloc, then alloc so alloc wins a
  // same-index collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_vld <= '0;
      rdy1      <= '0;
      rdy2      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        prs1[i] <= '0;
        prs2[i] <= '0;
      end
    end else if (bus.flush) begin
      entry_vld <= '0;
      rdy1      <= '0;
      rdy2      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        prs1[i] <= '0;
        prs2[i] <= '0;
      end
    end else begin
      rdy1 <= rdy1 | (hit1 & entry_vld);
      rdy2 <= rdy2 | (hit2 & entry_vld);
      if (bus.dealloc_en) entry_vld[dealloc_idx] <= 1'b0;
      if (bus.alloc_en) begin
        entry_vld[alloc_idx] <= 1'b1;
        prs1[alloc_idx]      <= bus.alloc_prs1;
        prs2[alloc_idx]      <= bus.alloc_prs2;
        rdy1[alloc_idx]      <= bus.alloc_rdy1 | byp1;
        rdy2[alloc_idx]      <= bus.alloc_rdy2 | byp2;
      end
    end
  end

  assign bus.entry_vld = entry_vld;
  assign bus.prs1_rdy  = rdy1;
  assign bus.prs2_rdy  = rdy2;
  assign bus.bcast_vld = bcast_vld;
  assign bus.bcast_tag = bcast_tag;

endmodule
